// File: rtl/btn_debounce_events_pkg.sv
// Shared event encoding for the button debounce/event block.
package btn_debounce_events_pkg;

  localparam int unsigned EVT_ID_W = 4;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b00,
    EVT_RELEASE = 2'b01,
    EVT_LONG    = 2'b10
  } evt_type_t;

endpackage

// File: rtl/btn_debounce_events_if.sv
// Event port towards the CPU-side register block (valid/ready plus overflow flag).
interface btn_debounce_events_if;
  import btn_debounce_events_pkg::*;

  logic                evt_valid;
  logic                evt_ready;
  logic [EVT_ID_W-1:0] evt_id;
  evt_type_t           evt_type;
  logic                evt_ovf;
  logic                ovf_clr;

  modport master (
    output evt_valid, evt_id, evt_type, evt_ovf,
    input  evt_ready, ovf_clr
  );

  modport slave (
    input  evt_valid, evt_id, evt_type, evt_ovf,
    output evt_ready, ovf_clr
  );
endinterface

// File: rtl/btn_debounce_chan.sv
// One button: 2-FF synchroniser, debounce counter, level and edge pulses.
// Optional hold counter for long presses when BTN_LONG_PRESS_EN is defined.
module btn_debounce_chan #(
  parameter int unsigned DEBOUNCE_CYC = 1000000
`ifdef BTN_LONG_PRESS_EN
  , parameter int unsigned LONG_CYC = 50000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYC);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync          <= '0;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync          <= {sync[0], raw};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        level         <= ~level;
        cnt           <= '0;
        press_pulse   <= ~level;
        release_pulse <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_CYC);

  logic [HW-1:0] hcnt;
  logic          hdone;

  // Counter saturates after firing so a held button reports long only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt       <= '0;
      hdone      <= 1'b0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (!level) begin
        hcnt  <= '0;
        hdone <= 1'b0;
      end else if (!hdone) begin
        if (hcnt == HW'(LONG_CYC - 1)) begin
          long_pulse <= 1'b1;
          hdone      <= 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_events.sv
// N-button debouncer with press/release(/long) event queueing onto a valid/ready port.
// Long-press events are built only when BTN_LONG_PRESS_EN is defined.
module btn_debounce_events
  import btn_debounce_events_pkg::*;
#(
  parameter int unsigned N_BTN        = 7,
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned LONG_CYC     = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_BTN-1:0]      btn_raw,
  output logic [N_BTN-1:0]      btn_level,
  output logic [N_BTN-1:0]      press_pulse,
  output logic [N_BTN-1:0]      release_pulse,
  output logic [N_BTN-1:0]      long_pulse,
  btn_debounce_events_if.master evt
);

  if (N_BTN < 1 || N_BTN > 16) begin : g_bad_n_btn
    $error("N_BTN must be 1..16");
  end
  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYC must be at least 2");
  end
  if (LONG_CYC < 2) begin : g_bad_long
    $error("LONG_CYC must be at least 2");
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
`ifdef BTN_LONG_PRESS_EN
      , .LONG_CYC(LONG_CYC)
`endif
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .raw          (btn_raw[g]),
      .level        (btn_level[g]),
      .press_pulse  (press_pulse[g]),
      .release_pulse(release_pulse[g]),
      .long_pulse   (long_pulse[g])
    );
  end

  logic [N_BTN-1:0]    press_p, rel_p, long_p;
  logic [N_BTN-1:0]    clr_press, clr_rel, clr_long;
  logic                load, found, ovf_set;
  logic [EVT_ID_W-1:0] sel_id;
  evt_type_t           sel_type;

  // Lowest index wins; within a button press > long > release.
  always_comb begin
    load      = !evt.evt_valid || evt.evt_ready;
    found     = 1'b0;
    sel_id    = '0;
    sel_type  = EVT_PRESS;
    clr_press = '0;
    clr_rel   = '0;
    clr_long  = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (!found && (press_p[i] || long_p[i] || rel_p[i])) begin
        found  = 1'b1;
        sel_id = EVT_ID_W'(i);
        if (press_p[i]) begin
          sel_type     = EVT_PRESS;
          clr_press[i] = load;
        end else if (long_p[i]) begin
          sel_type    = EVT_LONG;
          clr_long[i] = load;
        end else begin
          sel_type   = EVT_RELEASE;
          clr_rel[i] = load;
        end
      end
    end
    ovf_set = |((press_pulse & press_p & ~clr_press) |
                (release_pulse & rel_p & ~clr_rel) |
                (long_pulse & long_p & ~clr_long));
  end

  // A new pulse overrides a same-cycle clear of its flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_p <= '0;
      rel_p   <= '0;
    end else begin
      press_p <= press_pulse | (press_p & ~clr_press);
      rel_p   <= release_pulse | (rel_p & ~clr_rel);
    end
  end

`ifdef BTN_LONG_PRESS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) long_p <= '0;
    else     long_p <= long_pulse | (long_p & ~clr_long);
  end
`else
  assign long_p = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt.evt_valid <= 1'b0;
      evt.evt_id    <= '0;
      evt.evt_type  <= EVT_PRESS;
      evt.evt_ovf   <= 1'b0;
    end else begin
      if (load) begin
        evt.evt_valid <= found;
        if (found) begin
          evt.evt_id   <= sel_id;
          evt.evt_type <= sel_type;
        end
      end
      if (ovf_set)          evt.evt_ovf <= 1'b1;
      else if (evt.ovf_clr) evt.evt_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_debounce_events.sv
// Bench for btn_debounce_events: directed scenarios then random buttons/ready, against a behavioural model.
module tb_btn_debounce_events;
  localparam int unsigned N = 7;
  localparam int unsigned D = 4;
  localparam int unsigned L = 10;

  logic         clk, rst;
  logic [N-1:0] btn_raw, btn_level, press_pulse, release_pulse, long_pulse;
  btn_debounce_events_if evt_if();

  btn_debounce_events #(.N_BTN(N), .DEBOUNCE_CYC(D), .LONG_CYC(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .evt          (evt_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: level changes when the D synchronised samples before this edge all disagree with it.
  bit           hist [N][$];
  logic [N-1:0] m_lvl, m_pp, m_rp, m_lp, m_press_p, m_rel_p, m_long_p;
  logic         m_valid, m_ovf;
  logic [3:0]   m_id;
  logic [1:0]   m_type;
`ifdef BTN_LONG_PRESS_EN
  int           age [N];
  bit           fired [N];
`endif

  task automatic model_reset();
    m_lvl = '0; m_pp = '0; m_rp = '0; m_lp = '0;
    m_press_p = '0; m_rel_p = '0; m_long_p = '0;
    m_valid = 1'b0; m_ovf = 1'b0; m_id = '0; m_type = 2'b00;
    for (int i = 0; i < N; i++) begin
      hist[i].delete();
      for (int j = 0; j < D + 2; j++) hist[i].push_back(1'b0);
`ifdef BTN_LONG_PRESS_EN
      age[i] = 0;
      fired[i] = 1'b0;
`endif
    end
  endtask

  task automatic model_step(input logic [N-1:0] raw, input logic rdy, input logic clr);
    logic [N-1:0] o_lvl, o_pp, o_rp, o_lp, o_press, o_rel, o_long;
    logic [N-1:0] c_press, c_rel, c_long;
    bit flip, found;
    o_lvl = m_lvl; o_pp = m_pp; o_rp = m_rp; o_lp = m_lp;
    o_press = m_press_p; o_rel = m_rel_p; o_long = m_long_p;
    c_press = '0; c_rel = '0; c_long = '0;
    m_pp = '0; m_rp = '0; m_lp = '0;
    for (int i = 0; i < N; i++) begin
      hist[i].push_back(raw[i]);
      if (hist[i].size() > D + 2) void'(hist[i].pop_front());
      flip = 1'b1;
      for (int j = 0; j < D; j++) if (hist[i][j] == o_lvl[i]) flip = 1'b0;
      if (flip) begin
        m_lvl[i] = ~o_lvl[i];
        if (o_lvl[i]) m_rp[i] = 1'b1;
        else          m_pp[i] = 1'b1;
      end
`ifdef BTN_LONG_PRESS_EN
      if (o_lvl[i]) begin
        age[i]++;
        if (age[i] == L && !fired[i]) begin
          m_lp[i] = 1'b1;
          fired[i] = 1'b1;
        end
      end else begin
        age[i] = 0;
        fired[i] = 1'b0;
      end
`endif
    end
    if (!m_valid || rdy) begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!found && (o_press[i] || o_long[i] || o_rel[i])) begin
          found = 1'b1;
          m_id = 4'(i);
          if (o_press[i])     begin m_type = 2'b00; c_press[i] = 1'b1; end
          else if (o_long[i]) begin m_type = 2'b10; c_long[i] = 1'b1; end
          else                begin m_type = 2'b01; c_rel[i] = 1'b1; end
        end
      end
      m_valid = found;
    end
    m_press_p = o_pp | (o_press & ~c_press);
    m_rel_p   = o_rp | (o_rel & ~c_rel);
    m_long_p  = o_lp | (o_long & ~c_long);
    if (|((o_pp & o_press & ~c_press) | (o_rp & o_rel & ~c_rel) | (o_lp & o_long & ~c_long)))
      m_ovf = 1'b1;
    else if (clr)
      m_ovf = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("btn_level", btn_level, m_lvl);
    chk("press_pulse", press_pulse, m_pp);
    chk("release_pulse", release_pulse, m_rp);
    chk("long_pulse", long_pulse, m_lp);
    chk("evt_valid", evt_if.evt_valid, m_valid);
    chk("evt_id", evt_if.evt_id, m_id);
    chk("evt_type", evt_if.evt_type, m_type);
    chk("evt_ovf", evt_if.evt_ovf, m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(btn_raw, evt_if.evt_ready, evt_if.ovf_clr);
    #1;
    check_all();
  endtask

  int unsigned hold [N];
  int          long_cnt, long_evt, exp_long;

  initial begin
    rst = 1'b1; btn_raw = '0; evt_if.evt_ready = 1'b0; evt_if.ovf_clr = 1'b0;
    model_reset();
    step(); step();
    rst = 1'b0;
    chk("reset_valid", evt_if.evt_valid, 1'b0);

    // Clean press of button 2
    evt_if.evt_ready = 1'b1;
    btn_raw[2] = 1'b1;
    repeat (5) step();
    chk("t1_level_early", btn_level[2], 1'b0);
    step();
    chk("t1_level", btn_level[2], 1'b1);
    chk("t1_press_pulse", press_pulse[2], 1'b1);
    step();
    chk("t1_pulse_gone", press_pulse[2], 1'b0);
    step();
    chk("t1_evt_valid", evt_if.evt_valid, 1'b1);
    chk("t1_evt_id", evt_if.evt_id, 4'd2);
    chk("t1_evt_type", evt_if.evt_type, 2'b00);
    btn_raw[2] = 1'b0;
    repeat (12) step();

    // Glitch shorter than the debounce window
    btn_raw[0] = 1'b1;
    repeat (3) step();
    btn_raw[0] = 1'b0;
    repeat (10) step();
    chk("t2_glitch_level", btn_level[0], 1'b0);
    chk("t2_glitch_valid", evt_if.evt_valid, 1'b0);

    // Two presses in one cycle with the consumer stalled
    evt_if.evt_ready = 1'b0;
    btn_raw[1] = 1'b1; btn_raw[5] = 1'b1;
    repeat (8) step();
    chk("t3_valid", evt_if.evt_valid, 1'b1);
    chk("t3_id_first", evt_if.evt_id, 4'd1);
    repeat (3) step();
    chk("t3_id_stable", evt_if.evt_id, 4'd1);
    evt_if.evt_ready = 1'b1;
    step();
    chk("t3_id_second", evt_if.evt_id, 4'd5);
    chk("t3_valid_second", evt_if.evt_valid, 1'b1);
    step();
    chk("t3_drained", evt_if.evt_valid, 1'b0);
    btn_raw[1] = 1'b0; btn_raw[5] = 1'b0;
    repeat (12) step();

    // Overflow: register occupied, button 3 press/release/press
    evt_if.evt_ready = 1'b0;
    btn_raw[6] = 1'b1;
    repeat (8) step();
    btn_raw[3] = 1'b1;
    repeat (8) step();
    btn_raw[3] = 1'b0;
    repeat (8) step();
    btn_raw[3] = 1'b1;
    repeat (6) step();
    chk("t4_ovf_before", evt_if.evt_ovf, 1'b0);
    step();
    chk("t4_ovf_set", evt_if.evt_ovf, 1'b1);
    evt_if.ovf_clr = 1'b1;
    step();
    evt_if.ovf_clr = 1'b0;
    chk("t4_ovf_clr", evt_if.evt_ovf, 1'b0);
    evt_if.evt_ready = 1'b1;
    btn_raw[3] = 1'b0; btn_raw[6] = 1'b0;
    repeat (15) step();

    // Long hold of button 4
`ifdef BTN_LONG_PRESS_EN
    exp_long = 1;
`else
    exp_long = 0;
`endif
    long_cnt = 0; long_evt = 0;
    btn_raw[4] = 1'b1;
    repeat (40) begin
      step();
      if (long_pulse[4]) long_cnt++;
      if (evt_if.evt_valid && evt_if.evt_id == 4'd4 && evt_if.evt_type == 2'b10) long_evt++;
    end
    chk("t5_long_pulses", 16'(long_cnt), 16'(exp_long));
    chk("t5_long_events", 16'(long_evt), 16'(exp_long));
    btn_raw[4] = 1'b0;
    repeat (12) step();

    // Reset while an event is held and another button is mid-debounce
    evt_if.evt_ready = 1'b0;
    btn_raw[0] = 1'b1;
    repeat (8) step();
    chk("t6_valid_before", evt_if.evt_valid, 1'b1);
    btn_raw[1] = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    chk("t6_rst_valid", evt_if.evt_valid, 1'b0);
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("t6_level_early", btn_level[0], 1'b0);
    step();
    chk("t6_repress0", press_pulse[0], 1'b1);
    chk("t6_repress1", press_pulse[1], 1'b1);
    btn_raw = '0;
    evt_if.evt_ready = 1'b1;
    repeat (12) step();

    // Random buttons, ready and overflow clears
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 8);
    repeat (1500) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : $urandom_range(1, 8);
        end else begin
          hold[i]--;
        end
      end
      evt_if.evt_ready = ($urandom_range(0, 3) != 0);
      evt_if.ovf_clr   = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btn_debounce_events.md
# btn_debounce_events

Input-side companion to the LED output driver: samples N asynchronous push-buttons/switches, synchronises and debounces them, and turns clean level changes into press/release events. Events go out one at a time on a valid/ready port to the CPU-side register block. Sits between the board pins and the SoC peripheral bus bridge, in the same clock domain as the LED driver.

## Interface
- N_BTN, 7, number of button inputs (1..16)
- DEBOUNCE_CYC, 1000000, consecutive stable cycles required to accept a level change (≥2)
- LONG_CYC, 50000000, hold cycles for a long-press event (used only with long-press feature)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- btn_raw  in  N_BTN  raw pin levels, asynchronous, 1 = pressed
- btn_level  out  N_BTN  debounced levels
- press_pulse  out  N_BTN  one-cycle pulse on debounced 0→1
- release_pulse  out  N_BTN  one-cycle pulse on debounced 1→0
- long_pulse  out  N_BTN  one-cycle pulse on long press (0 when feature out)
- evt_valid  out  1  event register holds an event
- evt_ready  in  1  consumer accepts event when evt_valid & evt_ready
- evt_id  out  4  button index of event
- evt_type  out  2  00 press, 01 release, 10 long
- evt_ovf  out  1  sticky: an event was lost
- ovf_clr  in  1  clears evt_ovf

## Operation
- Per button: 2-FF synchroniser → debounce counter (width clog2(DEBOUNCE_CYC)) → level register.
- Counter clears whenever synchronised input equals btn_level; increments otherwise. When counter = DEBOUNCE_CYC-1 and still mismatched: btn_level flips, counter clears, matching pulse fires that cycle.
- Glitch shorter than DEBOUNCE_CYC cycles: no level change, no event.
- Per button, pending flags press_p, rel_p (long_p with feature) set the cycle after the corresponding pulse.
- Event register loads when !evt_valid or (evt_valid & evt_ready): pick lowest-index button with any pending flag; within a button priority press > long > release; clear the chosen flag in the same cycle. No pending → evt_valid drops after a transfer.
- Same-cycle set and clear of one flag: set wins, no overflow.
- Set of a flag already pending and not being cleared: flag stays 1, evt_ovf ← 1. ovf_clr clears evt_ovf; simultaneous new overflow wins.
- evt_id/evt_type stable while evt_valid & !evt_ready.

## Timing
- Reset values: btn_level 0, all pulses 0, pending flags 0, evt_valid 0, evt_id 0, evt_type 00, evt_ovf 0, synchronisers 0, counters 0.
- Raw change stable from edge k: synchronised at edge k+2, btn_level and pulse at edge k+1+DEBOUNCE_CYC.
- Pulse to pending: 1 cycle; pending to evt_valid: 1 cycle if event register free.
- Throughput: one event per cycle with evt_ready held high.
- Reset mid-debounce or mid-handshake: everything returns to reset values; pending events discarded; a held button re-reports press after full debounce.

## Configuration
- BTN_LONG_PRESS_EN defined: per-button hold counter counts while btn_level=1, clears on release; at LONG_CYC-1 fires long_pulse once per press (saturates, no repeat); evt_type 10 events produced.
- Undefined: no hold counter or long_p flags; long_pulse tied 0; evt_type 10 never appears.

## Structure
- Shared package: event type constants EVT_PRESS/EVT_RELEASE/EVT_LONG, evt_type typedef, evt_id width constant.
- Sub-module btn_debounce_chan: one synchroniser + debounce counter + level + pulses (+ hold counter); instantiated N_BTN times. Top holds pending flags, arbiter, event register, overflow.

## Test plan
- DEBOUNCE_CYC=4: btn_raw[2] 0→1 held → btn_level[2]=1 and press_pulse[2] exactly 5 edges later; evt id 2 type 00 one cycle after pending.
- btn_raw[0] high for 3 cycles then low → no level change, no event.
- evt_ready=0, press buttons 1 and 5 same cycle → evt_valid with id 1 held stable; raise evt_ready → id 1 then id 5 on consecutive cycles.
- evt_ready=0, press/release/press button 3 → second press sets evt_ovf=1; ovf_clr → evt_ovf=0.
- BTN_LONG_PRESS_EN, LONG_CYC=10: hold button 4 → press, then single long_pulse[4] and event type 10; release → type 01; no repeat long.
- Assert rst mid-debounce with evt_valid=1 → all outputs 0 next cycle; held button re-reports press after debounce.
